hid_report_axis_tx: RTL and testbench
=====================================

// Module: hid_report_axis_tx
// PURPOSE
//  Consumer end of the USB->AXI report crossing, in the axi_clk domain.
//  Takes the 64-bit HID report word and its level valid, produced by the CDC stage.
//  Turns each new report into exactly one AXI4-Stream beat, buffered through a small FIFO.
//  Reports arriving while the FIFO is full are dropped and counted.
// PARAMETERS
//  FIFO_DEPTH  8   entries in the report FIFO; power of two, >= 2
//  CNT_W       16  width of the saturating drop counter
// PORTS
//  axi_clk           in   1           system clock; all logic on posedge
//  rst               in   1           synchronous, active-high reset
//  usb_data_i        in   64          report word from CDC; stable while usb_data_valid_i high
//  usb_data_valid_i  in   1           level valid from CDC; each 0->1 edge is one new report
//  m_axis_tdata      out  64          report word at FIFO head
//  m_axis_tvalid     out  1           FIFO not empty
//  m_axis_tready     in   1           downstream ready
//  m_axis_tlast      out  1           constant 1; every report is a single-beat packet
//  fifo_level        out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
//  drop_cnt          out  CNT_W       reports lost to a full FIFO; saturates at all-ones
//  overflow          out  1           sticky; set on first drop, cleared only by rst
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - valid_q=0; FIFO empty; m_axis_tvalid=0; fifo_level=0; drop_cnt=0; overflow=0.
//   - m_axis_tdata is don't-care while tvalid=0.
//   - rst mid-transfer discards all buffered reports; no beat is emitted in the cycle rst is high.
//  Capture:
//   - valid_q registers usb_data_valid_i.
//   - push = usb_data_valid_i & ~valid_q.
//   - Data is sampled in the same cycle as the edge.
//   - A level held high yields one push only.
//   - If rst deasserts while valid is already high, that counts as an edge.
//  Pop:
//   - pop = m_axis_tvalid & m_axis_tready.
//   - tdata and tvalid must not change while tvalid=1 & tready=0 (AXIS rule).
//  Latency:
//   - Edge in cycle N into an empty FIFO -> tvalid=1 with that data in N+1.
//   - First-word fall-through.
//  FIFO:
//   - Pointers are $clog2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty.
//   - Pointers wrap modulo 2*FIFO_DEPTH.
//  Simultaneous events:
//   - push & pop when full: push accepted, level unchanged, no drop.
//   - push & pop when empty: impossible (pop needs tvalid); level goes to 1.
//   - push & pop otherwise: level unchanged, order preserved.
//  Drop:
//   - push while full & ~pop: report discarded.
//   - drop_cnt += 1 unless already all-ones.
//   - overflow <= 1.
//  Ordering: reports leave strictly in arrival order; no reordering, no duplication.
// CONFIGURATION
//  HID_REPORT_DEDUP_EN defined:
//   - A pushed report equal to last_rpt (the last report written to the FIFO) is silently discarded.
//   - Such discards are not counted in drop_cnt and do not set overflow.
//   - last_rpt_vld is cleared by rst, so the first report after reset is always accepted.
//   - last_rpt updates only on an actual FIFO write.
//  HID_REPORT_DEDUP_EN undefined:
//   - Every edge pushes.
//   - No last_rpt storage is synthesised.
// STRUCTURE
//  Package usb_hid_pkg:
//   - REPORT_W=64.
//   - typedef logic [REPORT_W-1:0] hid_report_t.
//   - Shared with the CDC stage.
//  Sub-module hid_report_fifo:
//   - Synchronous FWFT FIFO with params WIDTH and DEPTH.
//   - Ports: push/pop/din/dout/empty/full/level.
//  Top level holds edge detect, dedup, drop counter, overflow flag and AXIS mapping.
// TESTING
//  1. Reset, valid 0->1 with data 0x0123_4567_89AB_CDEF, tready=1
//     -> tvalid=1 and tdata=0x0123..EF exactly one cycle later, tlast=1, one beat only.
//  2. Valid held high for 10 cycles, then low, then high with 0x2
//     -> exactly two beats, data 0x1 then 0x2.
//  3. tready=0, 8 edges with data 1..8, then a 9th edge with 9
//     -> fifo_level=8, drop_cnt=1, overflow=1.
//     Then tready=1 -> beats 1..8 in order, 9 never appears.
//  4. FIFO full, edge coincides with a pop
//     -> no drop, level stays 8, new word exits last.
//  5. tready toggled randomly, 100 reports
//     -> tdata/tvalid stable during every stall; output sequence equals input sequence.
//  6. HID_REPORT_DEDUP_EN: reports 5,5,6,5
//     -> beats 5,6,5, drop_cnt=0.
//     rst mid-stream, then 5 -> beat 5 emitted.
//     Without the macro -> beats 5,5,6,5.

Source files
------------

// File: rtl/usb_hid_pkg.sv
// Shared definitions for the USB -> AXI HID report path.
// Used by the CDC stage and by the axi_clk-side consumer (hid_report_axis_tx).
//   REPORT_W      : width of one HID report word
//   hid_report_t  : one HID report word
package usb_hid_pkg;

  localparam int REPORT_W = 64;

  typedef logic [REPORT_W-1:0] hid_report_t;

endpackage

// File: rtl/hid_report_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head entry is visible on dout whenever empty is low.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (empties the FIFO)
//   push, din : write request and its data; accepted when not full, or when
//               full and a pop happens in the same cycle
//   pop       : remove the head entry; ignored while empty
//   dout      : head entry (undefined while empty)
//   empty     : no entries
//   full      : DEPTH entries
//   level     : current occupancy, 0..DEPTH
// Pointers carry one extra MSB so full and empty can be told apart; they
// wrap modulo 2*DEPTH.
module hid_report_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot index but different lap bit: writer is one full lap ahead.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the write can land there.
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hid_report_axis_tx.sv
// Consumer end of the USB -> AXI report crossing, axi_clk domain.
// Each 0->1 edge of the CDC level valid becomes one single-beat AXI4-Stream
// packet, buffered through a FWFT FIFO. Reports arriving while the FIFO is
// full (and not being drained that cycle) are dropped and counted.
// Optional build macro:
//   HID_REPORT_DEDUP_EN : discard a report equal to the last one written
//                         into the FIFO (not counted as a drop)
// Ports:
//   axi_clk, rst      : clock, synchronous active-high reset
//   usb_data_i        : report word from CDC, stable while valid is high
//   usb_data_valid_i  : level valid from CDC
//   m_axis_*          : AXI4-Stream master (tlast is always 1)
//   fifo_level        : FIFO occupancy, 0..FIFO_DEPTH
//   drop_cnt          : saturating count of reports lost to a full FIFO
//   overflow          : sticky, set on the first drop
// Handshake: a beat transfers on a cycle where m_axis_tvalid and
// m_axis_tready are both high; while tvalid is high and tready low, tdata
// and tvalid hold (the FIFO head only moves on a pop).
module hid_report_axis_tx
  import usb_hid_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             axi_clk,
  input  logic             rst,
  input  hid_report_t      usb_data_i,
  input  logic             usb_data_valid_i,
  output hid_report_t      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [LW-1:0]    fifo_level,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  logic valid_q;
  logic push;
  logic dup;
  logic fifo_push;
  logic fifo_wr;
  logic pop;
  logic drop;
  logic fifo_empty;
  logic fifo_full;

  // valid_q resets low, so a valid already high when rst releases is an edge.
  always_ff @(posedge axi_clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= usb_data_valid_i;
  end

  assign push = usb_data_valid_i & ~valid_q & ~rst;

`ifdef HID_REPORT_DEDUP_EN
  hid_report_t last_rpt;
  logic        last_rpt_vld;

  assign dup = last_rpt_vld && (usb_data_i == last_rpt);

  always_ff @(posedge axi_clk) begin
    if (rst)          last_rpt_vld <= 1'b0;
    else if (fifo_wr) last_rpt_vld <= 1'b1;
  end

  // Tracks only words actually written, so a dropped report never becomes
  // the comparison reference.
  always_ff @(posedge axi_clk) begin
    if (fifo_wr) last_rpt <= usb_data_i;
  end
`else
  assign dup = 1'b0;
`endif

  assign fifo_push = push & ~dup;
  assign fifo_wr   = fifo_push & (~fifo_full | pop);
  assign drop      = fifo_push & fifo_full & ~pop;

  // Gating with rst guarantees no beat is offered in a reset cycle.
  assign m_axis_tvalid = ~fifo_empty & ~rst;
  assign m_axis_tlast  = 1'b1;
  assign pop           = m_axis_tvalid & m_axis_tready;

  hid_report_fifo #(
    .WIDTH (REPORT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (axi_clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (pop),
    .din   (usb_data_i),
    .dout  (m_axis_tdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hid_report_axis_tx.sv
// Directed bench for hid_report_axis_tx: capture edges, latency, overflow,
// full-with-pop, random backpressure with ordering, reset discard, dedup.
module tb_hid_report_axis_tx;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LW    = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [63:0]      usb_data_i;
  logic             usb_data_valid_i;
  logic [63:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;

  hid_report_axis_tx #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .axi_clk          (clk),
    .rst              (rst),
    .usb_data_i       (usb_data_i),
    .usb_data_valid_i (usb_data_valid_i),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .fifo_level       (fifo_level),
    .drop_cnt         (drop_cnt),
    .overflow         (overflow)
  );

  // scoreboard
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    usb_data_i       = d;
    usb_data_valid_i = 1'b1;
    tick();
    usb_data_valid_i = 1'b0;
    tick();
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // Monitor on the falling edge: inputs and outputs are both stable here,
  // and a beat seen here transfers at the next rising edge.
  logic        stall_q    = 1'b0;
  logic [63:0] stall_data = '0;
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    if (!rst && stall_q) begin
      chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("stall_tdata", m_axis_tdata, stall_data);
    end
    stall_q    = !rst && m_axis_tvalid && !m_axis_tready;
    stall_data = m_axis_tdata;
  end

  initial begin
    rst              = 1'b1;
    usb_data_i       = '0;
    usb_data_valid_i = 1'b0;
    m_axis_tready    = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("tlast", 64'(m_axis_tlast), 64'd1);

    // 1: single edge, one-cycle latency, one beat
    m_axis_tready    = 1'b1;
    usb_data_i       = 64'h0123_4567_89AB_CDEF;
    usb_data_valid_i = 1'b1;
    tick();
    chk("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t1_tdata", m_axis_tdata, 64'h0123_4567_89AB_CDEF);
    chk("t1_tlast", 64'(m_axis_tlast), 64'd1);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    tick();
    chk("t1_after_tvalid", 64'(m_axis_tvalid), 64'd0);
    repeat (3) tick();
    check_beats("t1");

    // 2: level held high yields one push
    usb_data_valid_i = 1'b0;
    tick();
    usb_data_i       = 64'h1;
    usb_data_valid_i = 1'b1;
    repeat (10) tick();
    usb_data_valid_i = 1'b0;
    tick();
    usb_data_i       = 64'h2;
    usb_data_valid_i = 1'b1;
    tick();
    usb_data_valid_i = 1'b0;
    repeat (3) tick();
    exp_q.push_back(64'h1);
    exp_q.push_back(64'h2);
    check_beats("t2");

    // 3: fill with tready low, 9th report dropped
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send(64'(i));
      exp_q.push_back(64'(i));
    end
    chk("t3_level_full", 64'(fifo_level), 64'd8);
    send(64'd9);
    chk("t3_level", 64'(fifo_level), 64'd8);
    chk("t3_drop", 64'(drop_cnt), 64'd1);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_head", m_axis_tdata, 64'd1);
    m_axis_tready = 1'b1;
    repeat (12) tick();
    chk("t3_drained", 64'(fifo_level), 64'd0);
    check_beats("t3");

    // 4: edge coincides with pop while full
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send(64'h10 + 64'(i));
      exp_q.push_back(64'h10 + 64'(i));
    end
    usb_data_i       = 64'h19;
    usb_data_valid_i = 1'b1;
    m_axis_tready    = 1'b1;
    tick();
    exp_q.push_back(64'h19);
    usb_data_valid_i = 1'b0;
    chk("t4_level", 64'(fifo_level), 64'd8);
    chk("t4_drop", 64'(drop_cnt), 64'd1);
    chk("t4_head", m_axis_tdata, 64'h12);
    repeat (12) tick();
    check_beats("t4");

    // 5: random backpressure, 100 reports, order preserved
    for (int i = 0; i < 100; i++) begin
      usb_data_i       = {$urandom, $urandom};
      usb_data_valid_i = 1'b1;
      // A pop in the same cycle as a push into a full FIFO avoids a drop.
      m_axis_tready    = (fifo_level == LW'(DEPTH)) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_q.push_back(usb_data_i);
      tick();
      usb_data_valid_i = 1'b0;
      m_axis_tready    = 1'($urandom_range(0, 1));
      tick();
    end
    m_axis_tready = 1'b1;
    repeat (12) tick();
    chk("t5_drop", 64'(drop_cnt), 64'd1);
    check_beats("t5");

    // reset mid-stream discards buffered reports
    m_axis_tready = 1'b0;
    send(64'hAA);
    send(64'hBB);
    chk("rs_level_pre", 64'(fifo_level), 64'd2);
    rst = 1'b1;
    tick();
    chk("rs_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rs_level", 64'(fifo_level), 64'd0);
    chk("rs_drop", 64'(drop_cnt), 64'd0);
    chk("rs_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    check_beats("rs");

    // 6: 5,5,6,5
    send(64'd5);
    send(64'd5);
    send(64'd6);
    send(64'd5);
`ifdef HID_REPORT_DEDUP_EN
    exp_q.push_back(64'd5);
    exp_q.push_back(64'd6);
    exp_q.push_back(64'd5);
`else
    exp_q.push_back(64'd5);
    exp_q.push_back(64'd5);
    exp_q.push_back(64'd6);
    exp_q.push_back(64'd5);
`endif
    repeat (3) tick();
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    check_beats("t6");

    // reset with valid already high; release counts as an edge and the
    // repeated 5 is accepted after reset
    usb_data_i       = 64'd5;
    usb_data_valid_i = 1'b1;
    rst              = 1'b1;
    tick();
    chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    rst = 1'b0;
    tick();
    chk("t6_post_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t6_post_tdata", m_axis_tdata, 64'd5);
    exp_q.push_back(64'd5);
    usb_data_valid_i = 1'b0;
    repeat (3) tick();
    check_beats("t6_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
